// File: rtl/riscv_pkg.sv
// Shared types and helpers for the data-memory responder.
// Byte-enable encodings and the lane/alignment legality check live here.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_rsp_state_e;

    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Returns 1 when the mask is not a legal lane pattern or is misaligned.
    function automatic logic be_legal(input logic [1:0] addr_lo, input logic [3:0] we);
        case (we)
            BE_NONE, BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b0;
            BE_HALF0, BE_HALF1:                              be_legal = addr_lo[0];
            BE_WORD:                                         be_legal = (addr_lo != 2'b00);
            default:                                         be_legal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM bank with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       wr_be,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// WAIT_CYCLES, then commits/reads the bank and holds the response until taken.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_rsp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        rd_ok_q, rd_ok_d;

    logic             accept;
    logic [31:0]      eval_addr;
    logic [3:0]       eval_we;
    logic [31:0]      eval_wdata;
    logic             eval_err;
    logic             enter_resp;
    logic [3:0]       bank_we;
    logic             bank_re;
    logic [IDX_W-1:0] bank_idx;
    logic [31:0]      bank_rdata;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // error check and bank access must see the live request, not the holding regs.
    assign eval_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign eval_we    = (state_q == IDLE) ? req_we    : we_q;
    assign eval_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign eval_err = ({1'b0, eval_addr} < {1'b0, BASE_ADDR}) ||
                      ({1'b0, eval_addr} >= LIMIT) ||
                      be_legal(eval_addr[1:0], eval_we);

    assign enter_resp = !reset &&
                        (((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == 4'd1)));

    assign bank_idx = IDX_W'((eval_addr - BASE_ADDR) >> 2);
    assign bank_we  = (enter_resp && !eval_err) ? eval_we : 4'b0000;
    assign bank_re  = enter_resp && !eval_err && (eval_we == BE_NONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rd_ok_d = rd_ok_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d   = eval_err;
            rd_ok_d = !eval_err && (eval_we == BE_NONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .wr_be (bank_we),
        .rd_en (bank_re),
        .idx   (bank_idx),
        .wdata (eval_wdata),
        .rdata (bank_rdata)
    );

    assign rsp_valid = (state_q == RESP) && !reset;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && rd_ok_q) ? bank_rdata : 32'h0;

endmodule
